p2s_shift_64: RTL
=================

Name: p2s_shift_64

Overview:
- 64-bit parallel-to-serial shifter that sits directly downstream of the 64-bit 2:1 display-data mux.
- Captures the mux's selected 64-bit word on a start request and shifts it MSB-first onto the external serial shift-register chain (seven-segment / LED drivers).
- After the last bit it pulses a latch strobe so all drivers update at once.
- Generates its own divided serial clock from the system clock.

Parameters:
- DIV, 2: serial half-period in clk cycles; must be >= 1. One serial bit lasts 2*DIV clk cycles.
- WIDTH, 64: shift width; the block is verified only at 64.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to load par_data and begin shifting; sampled only in IDLE.
- par_data  input  WIDTH  parallel word (mux output); captured on the accepted start edge only.
- s_clk  output  1  serial shift clock to the external chain.
- s_data  output  1  serial data; stable for the whole s_clk high phase.
- s_clrn  output  1  active-low clear to the external chain.
- s_en  output  1  latch/output-enable strobe to the external chain.
- busy  output  1  high from the cycle after start is accepted until the transfer ends.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset is asynchronous and active-low: rst_n low forces, immediately:
  - state to IDLE;
  - s_clk, s_data, s_en, busy, done, shift register, bit counter and divider counter all to 0;
  - s_clrn to 0.
- s_clrn rises to 1 on the first clk edge after rst_n deasserts and stays 1 until the next reset.
- All outputs are registered.
- State machine: IDLE -> SHIFT -> LATCH -> IDLE.
- IDLE:
  - Outputs: s_clk=0, s_en=0, busy=0.
  - On an edge with start=1, capture par_data into the shift register, clear the bit and divider counters, and enter SHIFT; busy=1 from the next cycle.
- SHIFT, per bit:
  - Low phase, DIV cycles: s_clk=0 and s_data = shift_reg[WIDTH-1].
  - High phase, DIV cycles: s_clk=1 and s_data is held.
  - At the end of the high phase, shift the register left by 1, fill the LSB with 0, and increment the bit counter.
  - After bit 63's high phase, s_clk returns to 0 and the block enters LATCH. SHIFT lasts exactly 2*DIV*WIDTH cycles.
- LATCH:
  - s_clk=0 and s_en=1 for 2*DIV cycles.
  - Then return to IDLE: s_en=0 and busy=0, and done=1 for exactly that first IDLE cycle.
- Latency: start sampled at edge k -> busy high for 130*DIV cycles -> done high for the cycle following the last busy cycle. For DIV=2: busy for 260 cycles.
- Divider counter runs 0..DIV-1. Phase flips when the counter equals DIV-1. With DIV=1 the phase flips every cycle.
- Boundary conditions:
  - start while busy: ignored; par_data changes while busy have no effect.
  - start held high continuously: a new transfer begins on the done cycle, i.e. back-to-back with no gap cycle.
  - rst_n asserted mid-SHIFT or mid-LATCH: immediate abort to reset values, and done is not pulsed.
  - Multi-bit values: the X/Z-free par_data is transferred bit-exact. There is no arithmetic.

Optional Feature:
- Macro: P2S_AUTO_REFRESH_EN.
- When defined:
  - After each done, the block re-captures par_data and restarts automatically, regardless of start, so the display refreshes continuously.
  - The first transfer after reset still requires a start pulse.
  - Reset clears the auto-run flag.
- When undefined: a transfer occurs only on an explicit start.
- All other timing is identical in both builds.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle -> s_clk, s_data, s_en, busy, done and s_clrn read 0 immediately; one edge after release, s_clrn=1 and everything else stays 0.
- Single transfer, DIV=2, par_data=64'h8000_0000_0000_0001, start for 1 cycle:
  - s_data=1 for bit 0, 0 for bits 1..62, 1 for bit 63.
  - Exactly 64 s_clk rising edges, each spaced 4 cycles apart.
  - s_en high for 4 cycles, busy for 260 cycles, then a single done pulse.
- Pattern check, DIV=1, par_data=64'hA5A5_F00F_1234_5678: the bits captured on s_clk rising edges rebuild the word exactly; busy lasts 130 cycles.
- Start while busy: pulse start with par_data=64'hFFFF_FFFF_FFFF_FFFF mid-transfer -> no restart, and the original word completes unchanged.
- Reset mid-SHIFT: assert rst_n low after bit 20 -> all outputs drop to 0 at once, with no done pulse; a fresh start then transfers correctly.
- Back-to-back, or build with P2S_AUTO_REFRESH_EN: second transfer begins on the done cycle with no idle gap, and each transfer carries the par_data value present at its capture edge.

Source files
------------

// File: rtl/p2s_shift_64.sv
// p2s_shift_64: captures a parallel word on start and shifts it MSB-first onto
// an external serial shift-register chain using a divided serial clock, then
// pulses a latch strobe so every driver on the chain updates together.
// Optional build macro P2S_AUTO_REFRESH_EN: once started, the block re-captures
// par_data and restarts after every done without needing start again.
module p2s_shift_64 #(
  parameter int DIV   = 2,   // serial half-period in clk cycles (>= 1)
  parameter int WIDTH = 64   // shift width
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] par_data,
  output logic             s_clk,
  output logic             s_data,
  output logic             s_clrn,
  output logic             s_en,
  output logic             busy,
  output logic             done
);

  // Divider counter must also span the 2*DIV-cycle latch window.
  localparam int CW = $clog2(2 * DIV);
  localparam int BW = $clog2(WIDTH);

  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(2 * DIV - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [BW-1:0]    bit_cnt;
  logic [CW-1:0]    div_cnt;
  logic             go;

`ifdef P2S_AUTO_REFRESH_EN
  logic auto_run;

  // Once the first transfer is accepted, keep restarting after every done.
  assign go = start | auto_run;
`else
  assign go = start;
`endif

  // The serial data bit is the shift register MSB; it is a flop output, only
  // moves at the end of a high phase, and reads 0 once the word is shifted out.
  assign s_data = shift_reg[WIDTH-1];

  // Transfer sequencer: IDLE -> SHIFT -> LATCH -> IDLE with registered outputs.
  // s_clk doubles as the phase register (0 = low phase, 1 = high phase).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      s_clk     <= 1'b0;
      s_clrn    <= 1'b0;
      s_en      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef P2S_AUTO_REFRESH_EN
      auto_run  <= 1'b0;
`endif
    end else begin
      s_clrn <= 1'b1;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          s_clk <= 1'b0;
          s_en  <= 1'b0;
          busy  <= 1'b0;
          if (go) begin
            shift_reg <= par_data;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            busy      <= 1'b1;
            state     <= SHIFT;
`ifdef P2S_AUTO_REFRESH_EN
            auto_run  <= 1'b1;
`endif
          end
        end

        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!s_clk) begin
              s_clk <= 1'b1;
            end else begin
              // End of the high phase: advance to the next bit.
              s_clk     <= 1'b0;
              shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
              bit_cnt   <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_LAST) begin
                state <= LATCH;
                s_en  <= 1'b1;
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        LATCH: begin
          if (div_cnt == LATCH_LAST) begin
            div_cnt <= '0;
            state   <= IDLE;
            s_en    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
